// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants for the pass sequencer
//
// Purpose: state encodings, phase indices and watchdog defaults shared by
//          pass_sequencer and its bench-visible interface.
// Ports:   none (package).
package seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_F0_START = 4'd1;
  localparam state_t S_F0_WAIT  = 4'd2;
  localparam state_t S_F1_START = 4'd3;
  localparam state_t S_F1_WAIT  = 4'd4;
  localparam state_t S_B_START  = 4'd5;
  localparam state_t S_B_WAIT   = 4'd6;
  localparam state_t S_NEXT     = 4'd7;
  localparam state_t S_DONE     = 4'd8;
  localparam state_t S_ERR      = 4'd9;

  // Bit positions in the phase strobe vector.
  localparam int NUM_PHASES = 3;
  localparam int PH_F0      = 0;
  localparam int PH_F1      = 1;
  localparam int PH_B       = 2;

  localparam int DEFAULT_TIMEOUT = 200;
  localparam int DEFAULT_TO_W    = 8;

endpackage

// File: rtl/pass_sequencer_if.sv
// rtl/pass_sequencer_if.sv - pass handshake between sequencer and datapath
//
// Purpose: groups the per-pass handshake and phase strobes.
// Signals: pass_start - one-cycle start pulse for the current pass
//          f0_pass / f1_pass / b_pass - phase strobes (one-hot or zero)
//          pass_done - datapath completion of the current pass
// Modports: master = sequencer side, slave = datapath side.
interface pass_sequencer_if;

  logic pass_start;
  logic f0_pass;
  logic f1_pass;
  logic b_pass;
  logic pass_done;

  modport master (
    output pass_start,
    output f0_pass,
    output f1_pass,
    output b_pass,
    input  pass_done
  );

  modport slave (
    input  pass_start,
    input  f0_pass,
    input  f1_pass,
    input  b_pass,
    output pass_done
  );

endinterface

// File: rtl/pass_watchdog.sv
// rtl/pass_watchdog.sv - per-pass hang watchdog
//
// Purpose: counts enabled WAIT cycles of one pass and flags the cycle on
//          which the TIMEOUT-th WAIT cycle is being spent.
// Ports:   clk_i     - system clock
//          rst_i     - asynchronous active-low reset
//          clear_i   - restart the count (pass start or abort)
//          count_i   - this cycle is an enabled WAIT cycle
//          expired_o - this WAIT cycle is the TIMEOUT-th one
module pass_watchdog #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  // The count saturates at LAST so it can never wrap back to zero while a
  // stalled pass sits in WAIT with the sequencer not yet in ERR.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed, so LAST means
  // the current cycle is the TIMEOUT-th one.
  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/pass_sequencer.sv
// rtl/pass_sequencer.sv - training/inference pass scheduler
//
// Purpose: walks F0 -> F1 -> (B) passes over samples and epochs, issuing a
//          start pulse per pass, waiting for done and watchdogging each wait.
// Ports:   clk_i, rst_i (async active-low), en_i (global hold when 0)
//          init_i, infer_i, num_samples_i, num_epochs_i - job request/config
//          abort_i   - return to IDLE from any state
//          pass_bus  - start pulse, phase strobes and pass_done (master side)
//          sample_idx_o, epoch_idx_o - current position in the job
//          busy_o, done_o, timeout_o - status decodes
module pass_sequencer
  import seq_pkg::*;
#(
  parameter int SAMPLE_W = 4,
  parameter int EPOCH_W  = 4,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT,
  parameter int TO_W     = DEFAULT_TO_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                init_i,
  input  logic                infer_i,
  input  logic [SAMPLE_W-1:0] num_samples_i,
  input  logic [EPOCH_W-1:0]  num_epochs_i,
  input  logic                abort_i,
  pass_sequencer_if.master    pass_bus,
  output logic [SAMPLE_W-1:0] sample_idx_o,
  output logic [EPOCH_W-1:0]  epoch_idx_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);

  state_t                state_q;
  logic                  infer_q;
  logic [SAMPLE_W-1:0]   num_samples_q;
  logic [EPOCH_W-1:0]    num_epochs_q;
  logic [SAMPLE_W-1:0]   sample_q;
  logic [EPOCH_W-1:0]    epoch_q;
  logic                  in_start;
  logic                  in_wait;
  logic                  wd_clear;
  logic                  wd_count;
  logic                  wd_expired;
  logic [NUM_PHASES-1:0] phase;

  assign in_start = (state_q == S_F0_START) || (state_q == S_F1_START) ||
                    (state_q == S_B_START);
  assign in_wait  = (state_q == S_F0_WAIT) || (state_q == S_F1_WAIT) ||
                    (state_q == S_B_WAIT);

  assign wd_clear = en_i && (abort_i || in_start);
  assign wd_count = en_i && in_wait && !abort_i;

  pass_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .count_i   (wd_count),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      infer_q       <= 1'b0;
      num_samples_q <= '0;
      num_epochs_q  <= '0;
      sample_q      <= '0;
      epoch_q       <= '0;
    end else if (en_i) begin
      if (abort_i) begin
        state_q  <= S_IDLE;
        sample_q <= '0;
        epoch_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (init_i) begin
              infer_q       <= infer_i;
              num_samples_q <= num_samples_i;
              num_epochs_q  <= num_epochs_i;
              sample_q      <= '0;
              epoch_q       <= '0;
              state_q       <= S_F0_START;
            end
          end
          S_F0_START: state_q <= S_F0_WAIT;
          S_F1_START: state_q <= S_F1_WAIT;
          S_B_START:  state_q <= S_B_WAIT;
          // done is tested before expiry so a same-cycle done still wins.
          S_F0_WAIT: begin
            if (pass_bus.pass_done)  state_q <= S_F1_START;
            else if (wd_expired)     state_q <= S_ERR;
          end
          S_F1_WAIT: begin
            if (pass_bus.pass_done)  state_q <= infer_q ? S_NEXT : S_B_START;
            else if (wd_expired)     state_q <= S_ERR;
          end
          S_B_WAIT: begin
            if (pass_bus.pass_done)  state_q <= S_NEXT;
            else if (wd_expired)     state_q <= S_ERR;
          end
          // Limits are compared before incrementing, so indices never wrap.
          S_NEXT: begin
            if (sample_q < num_samples_q) begin
              sample_q <= sample_q + 1'b1;
              state_q  <= S_F0_START;
            end else if (epoch_q < num_epochs_q) begin
              sample_q <= '0;
              epoch_q  <= epoch_q + 1'b1;
              state_q  <= S_F0_START;
            end else begin
              state_q  <= S_DONE;
            end
          end
          S_ERR:   state_q <= S_ERR;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    phase = '0;
    case (state_q)
      S_F0_START, S_F0_WAIT: phase[PH_F0] = 1'b1;
      S_F1_START, S_F1_WAIT: phase[PH_F1] = 1'b1;
      S_B_START,  S_B_WAIT:  phase[PH_B]  = 1'b1;
      default:               phase        = '0;
    endcase
  end

  assign pass_bus.f0_pass    = phase[PH_F0];
  assign pass_bus.f1_pass    = phase[PH_F1];
  assign pass_bus.b_pass     = phase[PH_B];
  assign pass_bus.pass_start = in_start;

  assign sample_idx_o = sample_q;
  assign epoch_idx_o  = epoch_q;
  assign busy_o       = !((state_q == S_IDLE) || (state_q == S_DONE) ||
                          (state_q == S_ERR));
  assign done_o       = (state_q == S_DONE);
  assign timeout_o    = (state_q == S_ERR);

endmodule

// File: tb/tb_pass_sequencer.sv
// tb/tb_pass_sequencer.sv - self-checking bench for pass_sequencer
module tb_pass_sequencer;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       init_i;
  logic       infer_i;
  logic       abort_i;
  logic [3:0] num_samples_i;
  logic [3:0] num_epochs_i;
  logic [3:0] sample_idx_o;
  logic [3:0] epoch_idx_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  pass_sequencer_if pif ();

  pass_sequencer #(
    .SAMPLE_W (4),
    .EPOCH_W  (4),
    .TIMEOUT  (200),
    .TO_W     (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .init_i        (init_i),
    .infer_i       (infer_i),
    .num_samples_i (num_samples_i),
    .num_epochs_i  (num_epochs_i),
    .abort_i       (abort_i),
    .pass_bus      (pif),
    .sample_idx_o  (sample_idx_o),
    .epoch_idx_o   (epoch_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] strb();
    return {pif.b_pass, pif.f1_pass, pif.f0_pass};
  endfunction

  // {start, b, f1, f0, busy, done, timeout, sample[3:0], epoch[3:0]}
  function automatic logic [14:0] all_out();
    return {pif.pass_start, strb(), busy_o, done_o, timeout_o, sample_idx_o, epoch_idx_o};
  endfunction

  task automatic launch(input bit inf, input int ns, input int ne);
    infer_i       = inf;
    num_samples_i = 4'(ns);
    num_epochs_i  = 4'(ne);
    init_i        = 1'b1;
    @(negedge clk);
    init_i        = 1'b0;
  endtask

  // Full job with the datapath answering done on the lat-th WAIT cycle.
  task automatic run_job(input bit inf, input int ns, input int ne, input int lat, input bit noise);
    int         exp_q[$];
    int         n_pass, n_smp, exp_cycles, cycles, w, cur_ph, starts, ent;
    logic [3:0] prev_s, prev_e;
    bit         prev_next;
    logic [2:0] st;
    for (int e = 0; e <= ne; e++)
      for (int s = 0; s <= ns; s++)
        for (int ph = 0; ph < (inf ? 2 : 3); ph++)
          exp_q.push_back((e << 8) | (s << 4) | ph);
    n_pass     = exp_q.size();
    n_smp      = (ns + 1) * (ne + 1);
    exp_cycles = n_pass * (1 + lat) + n_smp + 1;
    launch(inf, ns, ne);
    cycles = 1; w = 0; cur_ph = 0; starts = 0;
    prev_s = 4'd0; prev_e = 4'd0; prev_next = 1'b0;
    while (!done_o && cycles <= exp_cycles + 20) begin
      st = strb();
      if (sample_idx_o !== prev_s || epoch_idx_o !== prev_e)
        chk("idx_moves_only_after_next", 32'(prev_next), 1);
      chk("strobe_onehot", 32'($onehot0(st)), 1);
      pif.pass_done = 1'b0;
      init_i        = 1'b0;
      if (pif.pass_start) begin
        starts++;
        w = 0;
        if (exp_q.size() == 0) begin
          chk("extra_pass_start", starts, n_pass);
        end else begin
          ent    = exp_q.pop_front();
          cur_ph = ent & 3;
          chk("start_phase", 32'(st), 1 << cur_ph);
          chk("start_sample", 32'(sample_idx_o), (ent >> 4) & 15);
          chk("start_epoch", 32'(epoch_idx_o), ent >> 8);
        end
        if (noise) pif.pass_done = 1'($urandom_range(0, 1));
      end else if (st != 3'b000) begin
        chk("wait_phase", 32'(st), 1 << cur_ph);
        w++;
        if (w == lat) pif.pass_done = 1'b1;
      end else if (noise) begin
        pif.pass_done = 1'($urandom_range(0, 1));
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        init_i        = 1'b1;
        infer_i       = 1'($urandom);
        num_samples_i = 4'($urandom);
        num_epochs_i  = 4'($urandom);
      end
      prev_next = busy_o && (st == 3'b000) && !pif.pass_start;
      prev_s    = sample_idx_o;
      prev_e    = epoch_idx_o;
      @(negedge clk);
      cycles++;
    end
    pif.pass_done = 1'b0;
    init_i        = 1'b0;
    chk("job_cycles", cycles, exp_cycles);
    chk("job_pass_starts", starts, n_pass);
    chk("job_passes_left", exp_q.size(), 0);
    chk("job_status", {busy_o, done_o, timeout_o}, 3'b010);
    chk("job_final_sample", 32'(sample_idx_o), ns);
    chk("job_final_epoch", 32'(epoch_idx_o), ne);
  endtask

  // Answer every pass after one WAIT cycle until the given phase WAIT at sample s.
  task automatic seek(input int ph, input int s, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (strb() == 3'(1 << ph) && !pif.pass_start && sample_idx_o == 4'(s)) begin
        hit = 1'b1;
        break;
      end
      pif.pass_done = (strb() != 3'b000) && !pif.pass_start;
      @(negedge clk);
    end
    pif.pass_done = 1'b0;
  endtask

  initial begin
    int w;
    bit hit;
    rst_i = 1'b0; en_i = 1'b1; init_i = 1'b0; infer_i = 1'b0; abort_i = 1'b0;
    num_samples_i = 4'd0; num_epochs_i = 4'd0; pif.pass_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(all_out()), 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'(all_out()), 0);

    run_job(1'b0, 0, 0, 1, 1'b0);
    run_job(1'b0, 2, 1, 1, 1'b0);
    run_job(1'b1, 3, 0, 1, 1'b0);
    repeat (6) run_job(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       $urandom_range(0, 2), $urandom_range(1, 5), 1'b1);
    run_job(1'b1, 0, 0, 200, 1'b0);

    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("done_abort_to_idle", 32'(all_out()), 0);

    launch(1'b0, 0, 0);
    @(negedge clk);
    pif.pass_done = 1'b1;
    @(negedge clk);
    pif.pass_done = 1'b0;
    chk("f1_start", {pif.pass_start, strb()}, 4'b1010);
    w = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (timeout_o) break;
      if (strb() == 3'b010 && !pif.pass_start) w++;
    end
    chk("f1_wait_cycles_to_err", w, 200);
    chk("err_outputs", {pif.pass_start, strb(), busy_o, done_o, timeout_o}, 7'b0000001);
    init_i = 1'b1; num_samples_i = 4'd5; pif.pass_done = 1'b1;
    @(negedge clk);
    init_i = 1'b0; pif.pass_done = 1'b0;
    chk("err_ignores_init", {pif.pass_start, busy_o, done_o, timeout_o}, 4'b0001);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("err_abort_to_idle", 32'(all_out()), 0);

    launch(1'b0, 0, 0);
    w = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (strb() == 3'b001 && !pif.pass_start) w++;
      if (w == 50) break;
    end
    en_i = 1'b0; pif.pass_done = 1'b1; init_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("en_low_hold_mid", 32'(all_out()), 32'(15'b0_001_100_0000_0000));
    repeat (5) @(negedge clk);
    chk("en_low_hold_end", 32'(all_out()), 32'(15'b0_001_100_0000_0000));
    en_i = 1'b1; pif.pass_done = 1'b0; init_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (timeout_o) break;
      if (strb() == 3'b001 && !pif.pass_start) w++;
    end
    chk("f0_enabled_wait_cycles", w, 200);
    chk("f0_err_flag", 32'(timeout_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;

    launch(1'b0, 2, 1);
    seek(2, 1, hit);
    chk("seek_b_wait", 32'(hit), 1);
    chk("b_wait_status", {busy_o, sample_idx_o}, 5'b1_0001);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("b_wait_abort_to_idle", 32'(all_out()), 0);

    launch(1'b1, 3, 1);
    seek(1, 2, hit);
    chk("seek_f1_wait", 32'(hit), 1);
    chk("pre_reset_busy", 32'(busy_o), 1);
    #2 rst_i = 1'b0;
    #1 chk("reset_mid_pass", 32'(all_out()), 0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    run_job(1'b0, 1, 0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
